uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing one UART transmit engine (FSMTX-style serializer) between NREQ byte requesters. Accepts one byte at a time via valid/ready, loads it into the transmitter with a start pulse, waits for the transmitter's done pulse, then enforces an idle-line guard gap before the next grant. A watchdog abandons a frame whose done never arrives and raises a sticky error.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width,
// default timing parameters and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } uart_state_e;

  localparam int BYTE_W                 = 8;
  localparam int DEFAULT_GAP_CYCLES     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1, wrapping modulo NREQ.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] cand_s;

  // Walk candidates ptr+1 .. ptr+NREQ and keep the first requester found.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = PW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand_s]) begin
        any           = 1'b1;
        idx           = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte
// requesters, with idle-line guard gap and a watchdog on the done pulse.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PW       = $clog2(NREQ);
  localparam int WD_W     = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W    = cnt_width(GAP_CYCLES);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int WD_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam uart_state_e POST_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  uart_state_e       state_r;
  uart_state_e       state_s;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     grant_id_r;
  logic [PW-1:0]     pick_idx_s;
  logic [NREQ-1:0]   pick_grant_s;
  logic              pick_any_s;
  logic              accept_s;
  logic              frame_end_s;
  logic              wd_expire_s;
  logic [BYTE_W-1:0] sel_byte_s;
  logic [BYTE_W-1:0] tx_data_r;
  logic [WD_W-1:0]   wd_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              tx_start_r;
  logic              busy_r;
  logic              timeout_err_r;

  uart_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_r),
    .grant(pick_grant_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Handshake, selected byte mux and end-of-frame decode.
  always_comb begin
    accept_s    = 1'b0;
    req_ready   = '0;
    frame_end_s = 1'b0;
    wd_expire_s = 1'b0;
    sel_byte_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_byte_s = sel_byte_s | (req_data[BYTE_W*i +: BYTE_W] & {BYTE_W{pick_grant_s[i]}});
    end
    if ((state_r == ST_IDLE) && !rst) begin
      accept_s  = pick_any_s;
      req_ready = pick_grant_s;
    end else begin
      accept_s  = 1'b0;
      req_ready = '0;
    end
    // done in the expiry cycle ends the frame cleanly, without an error
    if (state_r == ST_WAIT) begin
      frame_end_s = tx_done || (wd_cnt_r == WD_W'(WD_LAST));
      wd_expire_s = !tx_done && (wd_cnt_r == WD_W'(WD_LAST));
    end else begin
      frame_end_s = 1'b0;
      wd_expire_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (frame_end_s) begin
          state_s = POST_FRAME;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, arbitration pointer and the captured frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= PW'(NREQ - 1);
      grant_id_r <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= accept_s;
      busy_r     <= (state_s != ST_IDLE);
      if (accept_s) begin
        ptr_r      <= pick_idx_s;
        grant_id_r <= pick_idx_s;
        tx_data_r  <= sel_byte_s;
      end
    end
  end

  // Watchdog and guard-gap counters plus the sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r      <= '0;
      gap_cnt_r     <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == ST_START) begin
        wd_cnt_r <= '0;
      end else if ((state_r == ST_WAIT) && !frame_end_s) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
      if ((state_r == ST_GAP) && (gap_cnt_r != GAP_W'(GAP_LAST))) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= '0;
      end
      if (wd_expire_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter plus a short directed run
// on a GAP_CYCLES=0 build.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 50;
  localparam int RUN   = 4000;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  logic              g0_rst;
  logic [NREQ-1:0]   g0_valid;
  logic [8*NREQ-1:0] g0_data;
  logic [NREQ-1:0]   g0_ready;
  logic              g0_tx_start;
  logic [7:0]        g0_tx_data;
  logic              g0_done;
  logic [1:0]        g0_grant_id;
  logic              g0_busy;
  logic              g0_timeout_err;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_g0 (
    .clk(clk), .rst(g0_rst), .req_valid(g0_valid), .req_data(g0_data),
    .req_ready(g0_ready), .tx_start(g0_tx_start), .tx_data(g0_tx_data),
    .tx_done(g0_done), .grant_id(g0_grant_id), .busy(g0_busy), .timeout_err(g0_timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         id;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] rq[NREQ][$];

  // Reference model: arbiter is either open for a grant or busy until a
  // precomputed reopen cycle derived from the frame timeline.
  bit open;
  int last, start_c, end_c, done_at, reopen, err_at;
  bit g0_fin = 1'b0;

  task automatic model_reset();
    sbq.delete();
    open    = 1'b0;
    last    = NREQ - 1;
    start_c = -10;
    end_c   = -10;
    done_at = -1;
    reopen  = -1;
    err_at  = NEVER;
  endtask

  task automatic model_step();
    int c;
    int w;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    c = cyc;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
    end else begin
      if (!open && c == reopen) open = 1'b1;
      check("busy", 32'(busy), 32'(!open));
      check("timeout_err", 32'(timeout_err), 32'(c >= err_at));
      exp_rdy = '0;
      if (open && req_valid != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (last + k) % NREQ;
          if (w < 0 && req_valid[j]) w = j;
        end
        exp_rdy[w] = 1'b1;
        e.data = rq[w][0];
        e.id   = w;
        e.due  = c + 1;
        sbq.push_back(e);
        void'(rq[w].pop_front());
        last    = w;
        open    = 1'b0;
        start_c = c + 1;
        case ($urandom_range(0, 9))
          0: begin
            done_at = -1;
            end_c   = start_c + TMO;
            if (err_at > end_c + 1) err_at = end_c + 1;
          end
          1: begin
            done_at = start_c + TMO;
            end_c   = done_at;
          end
          default: begin
            done_at = start_c + int'($urandom_range(1, 8));
            end_c   = done_at;
          end
        endcase
        reopen = end_c + GAP + 1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
    end
  endtask

  task automatic drive(input bit force01, input bit nomask);
    bit in_wait;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() == 0 && ($urandom_range(0, 2) == 0 || (force01 && i < 2)))
        rq[i].push_back(8'($urandom));
      if (rq[i].size() > 0 && (nomask || force01 || $urandom_range(0, 4) != 0) &&
          (!force01 || i < 2)) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = rq[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
      end
    end
    in_wait = !open && cyc > start_c && cyc <= end_c;
    tx_done = (cyc == done_at) || (!in_wait && $urandom_range(0, 9) == 0);
  endtask

  // Stimulus and reference-model process.
  initial begin
    int hold;
    bit mid_done;
    hold      = 0;
    mid_done  = 1'b0;
    rst       = 1'b1;
    tx_done   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    model_reset();
    for (int k = 0; k < RUN; k++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #2;
      if (k == 3) begin
        rst  = 1'b0;
        open = 1'b1;
        drive(1'b0, 1'b1);
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          rst  = 1'b0;
          open = 1'b1;
        end
        drive(1'b1, 1'b1);
      end else if (rst) begin
        drive(1'b0, 1'b1);
      end else if (k >= 2000 && !mid_done && !open && cyc > start_c && cyc < end_c) begin
        drive(1'b1, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        model_reset();
        hold     = 2;
        mid_done = 1'b1;
      end else begin
        drive(1'b0, (k % 1000) >= 700);
      end
    end
    for (int t = 0; t < 100 && !g0_fin; t++) @(posedge clk);
    check("g0_finished", 32'(g0_fin), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Scoreboard monitor: every tx_start pops and checks the expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (sbq.size() == 0) begin
          check("tx_start_unexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("tx_start_cycle", 32'(cyc), 32'(e.due));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check("tx_start_missing", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  // Directed run on the zero-gap build, including ignored done pulses.
  initial begin
    g0_rst   = 1'b1;
    g0_valid = '0;
    g0_data  = '0;
    g0_done  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    g0_rst   = 1'b0;
    g0_valid = 4'b0100;
    g0_data  = 32'h00A5_0000;
    @(negedge clk);
    check("g0_ready", 32'(g0_ready), 32'h4);
    check("g0_busy_idle", 32'(g0_busy), 32'd0);
    @(posedge clk); #2;
    g0_valid = '0;
    g0_done  = 1'b1;
    @(negedge clk);
    check("g0_tx_start", 32'(g0_tx_start), 32'd1);
    check("g0_tx_data", 32'(g0_tx_data), 32'hA5);
    check("g0_grant_id", 32'(g0_grant_id), 32'd2);
    @(posedge clk); #2;
    g0_done = 1'b0;
    @(negedge clk);
    check("g0_busy_wait", 32'(g0_busy), 32'd1);
    check("g0_tx_start_once", 32'(g0_tx_start), 32'd0);
    @(posedge clk); #2;
    g0_done = 1'b1;
    @(negedge clk);
    check("g0_busy_done", 32'(g0_busy), 32'd1);
    @(posedge clk); #2;
    g0_done = 1'b0;
    @(negedge clk);
    check("g0_idle_after_done", 32'(g0_busy), 32'd0);
    check("g0_err", 32'(g0_timeout_err), 32'd0);
    @(posedge clk); #2;
    g0_done = 1'b1;
    @(negedge clk);
    check("g0_idle_spurious", 32'(g0_busy), 32'd0);
    @(posedge clk); #2;
    g0_done = 1'b0;
    @(negedge clk);
    check("g0_no_start", 32'(g0_tx_start), 32'd0);
    check("g0_err_spurious", 32'(g0_timeout_err), 32'd0);
    g0_fin = 1'b1;
  end

endmodule
